// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_controller_if;
  // Datapath status, consumed by the controller
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;

  // Datapath controls, produced by the controller
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       err;

  modport master (
    input  op, funct, zero, memready,
    output pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol, state, err
  );

  modport slave (
    output op, funct, zero, memready,
    input  pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol, state, err
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: instruction-sequencing FSM, ALU decoder,
// memory-ready stalls on fetch/load/store and a sticky error state for
// undefined opcodes or R-type funct codes.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_ERR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  // With the handshake disabled every memory access completes in one cycle.
  logic rdy;
  assign rdy = MEM_HANDSHAKE ? bus.memready : 1'b1;

  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       err;

  logic [2:0] rtype_alu;
  logic       funct_legal;

  // ALU decoder for R-type funct codes; also flags funct codes we do not implement.
  always_comb begin
    rtype_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (bus.funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   funct_legal = 1'b0;
    endcase
  end

  // State register; reset always returns to instruction fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath controls, decoded from the current state and inputs.
  always_comb begin
    state_d    = state_q;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    err        = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed in parallel with the instruction read.
        alusrcb = 2'b01;
        irwrite = rdy;
        pcen    = rdy;
        if (rdy) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target speculatively placed in aluout.
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal ? S_RTYPEEX : S_ERR;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_ERR;
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe is held for the whole stall so slow memory sees a stable write.
        iord     = 1'b1;
        memwrite = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
        end
      end

      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = bus.zero;
        state_d    = S_FETCH;
      end

      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ~bus.zero;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JEX: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end

      S_ERR: begin
        // Sticky until reset; every enable stays low.
        err = 1'b1;
      end

      default: begin
        // Unused encodings recover to fetch.
        state_d = S_FETCH;
      end
    endcase

    // No architectural state may change while reset is held.
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign bus.pcen       = pcen;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.memwrite   = memwrite;
  assign bus.alusrca    = alusrca;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;
  assign bus.err        = err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Each instruction is expanded into a
// per-cycle script of expected state and control values (including memory
// stall cycles) which is then played against the design.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus_hs ();
  multicycle_controller_if bus_nh ();

  multicycle_controller #(.MEM_HANDSHAKE(1'b1)) u_hs (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hs.master)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1'b0)) u_nh (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nh.master)
  );

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4,
                 K_ADDI = 5, K_J = 6, K_BADOP = 7, K_BADFN = 8;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [15:0] ov;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // {pcen,irwrite,regwrite,memwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol,err}
  function automatic logic [15:0] ov(input logic pcen, input logic irw, input logic rw,
                                     input logic mw, input logic srca, input logic iord,
                                     input logic m2r, input logic rdst, input logic [1:0] srcb,
                                     input logic [1:0] pcs, input logic [2:0] alu, input logic e);
    return {pcen, irw, rw, mw, srca, iord, m2r, rdst, srcb, pcs, alu, e};
  endfunction

  function automatic logic [15:0] act(input bit nh);
    if (nh)
      return {bus_nh.pcen, bus_nh.irwrite, bus_nh.regwrite, bus_nh.memwrite, bus_nh.alusrca,
              bus_nh.iord, bus_nh.memtoreg, bus_nh.regdst, bus_nh.alusrcb, bus_nh.pcsrc,
              bus_nh.alucontrol, bus_nh.err};
    return {bus_hs.pcen, bus_hs.irwrite, bus_hs.regwrite, bus_hs.memwrite, bus_hs.alusrca,
            bus_hs.iord, bus_hs.memtoreg, bus_hs.regdst, bus_hs.alusrcb, bus_hs.pcsrc,
            bus_hs.alucontrol, bus_hs.err};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
           o == 6'b000101 || o == 6'b001000 || o == 6'b000010;
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [15:0] v);
    cyc_t c;
    c.st = st;
    c.mr = mr;
    c.ov = v;
    q.push_back(c);
  endtask

  // Expand one instruction into its expected cycle script.
  task automatic build(input int kind, input logic [5:0] fn, input logic z,
                       input int fs, input int ms, input int errc);
    for (int i = 0; i < fs; i++) push(4'd0, 1'b0, ov(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    push(4'd0, 1'b1, ov(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    push(4'd1, rb(), ov(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    case (kind)
      K_LW: begin
        push(4'd2, rb(), ov(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010,0));
        for (int i = 0; i < ms; i++) push(4'd3, 1'b0, ov(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0));
        push(4'd3, 1'b1, ov(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0));
        push(4'd4, rb(), ov(0,0,1,0,0,0,1,0,2'b00,2'b00,3'b010,0));
      end
      K_SW: begin
        push(4'd2, rb(), ov(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010,0));
        for (int i = 0; i < ms; i++) push(4'd5, 1'b0, ov(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0));
        push(4'd5, 1'b1, ov(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0));
      end
      K_R: begin
        push(4'd6, rb(), ov(0,0,0,0,1,0,0,0,2'b00,2'b00,alu_of(fn),0));
        push(4'd7, rb(), ov(0,0,1,0,0,0,0,1,2'b00,2'b00,3'b010,0));
      end
      K_BEQ: push(4'd8, rb(), ov(z,0,0,0,1,0,0,0,2'b00,2'b01,3'b110,0));
      K_BNE: push(4'd12, rb(), ov(~z,0,0,0,1,0,0,0,2'b00,2'b01,3'b110,0));
      K_ADDI: begin
        push(4'd9, rb(), ov(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010,0));
        push(4'd10, rb(), ov(0,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0));
      end
      K_J: push(4'd11, rb(), ov(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0));
      default: begin
        for (int i = 0; i < errc; i++) push(4'd13, rb(), ov(0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,1));
      end
    endcase
  endtask

  // Play the script: entered and left just after a rising edge.
  task automatic run_q(input bit nh, input string tag);
    cyc_t c;
    logic [3:0] st;
    logic [15:0] a;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus_hs.memready = c.mr;
      bus_nh.memready = 1'b0;
      @(negedge clk);
      st = nh ? bus_nh.state : bus_hs.state;
      a  = act(nh);
      checks++;
      if (st !== c.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", tag, st, c.st);
      end
      checks++;
      if (a !== c.ov) begin
        errors++;
        $display("FAIL %s controls (state %0d): got %b expected %b", tag, c.st, a, c.ov);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] fn, input logic z);
    bus_hs.op = o;  bus_hs.funct = fn;  bus_hs.zero = z;
    bus_nh.op = o;  bus_nh.funct = fn;  bus_nh.zero = z;
  endtask

  task automatic pick(input int kind, output logic [5:0] o, output logic [5:0] fn);
    logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    fn = legal_fns[$urandom_range(0, 4)];
    case (kind)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_R:    o = 6'b000000;
      K_BEQ:  o = 6'b000100;
      K_BNE:  o = 6'b000101;
      K_ADDI: o = 6'b001000;
      K_J:    o = 6'b000010;
      K_BADOP: begin
        o = 6'($urandom_range(0, 63));
        while (legal_op(o)) o = 6'($urandom_range(0, 63));
      end
      default: begin
        o = 6'b000000;
        fn = 6'($urandom_range(0, 63));
        while (legal_fn(fn)) fn = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus_hs.memready = 1'b1;
    bus_nh.memready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_hs.pcen, bus_hs.irwrite, bus_hs.regwrite, bus_hs.memwrite,
         bus_nh.pcen, bus_nh.irwrite, bus_nh.regwrite, bus_nh.memwrite} !== 8'h00) begin
      errors++;
      $display("FAIL %s enables during reset: got hs=%b%b%b%b nh=%b%b%b%b expected all 0", tag,
               bus_hs.pcen, bus_hs.irwrite, bus_hs.regwrite, bus_hs.memwrite,
               bus_nh.pcen, bus_nh.irwrite, bus_nh.regwrite, bus_nh.memwrite);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus_hs.state !== 4'd0 || bus_nh.state !== 4'd0) begin
      errors++;
      $display("FAIL %s state after reset: got hs=%0d nh=%0d expected 0", tag, bus_hs.state, bus_nh.state);
    end
  endtask

  task automatic run_instr(input int kind, input logic z, input int fs, input int ms,
                           input int errc, input bit nh, input string tag);
    logic [5:0] o, fn;
    pick(kind, o, fn);
    set_instr(o, fn, z);
    build(kind, fn, z, nh ? 0 : fs, nh ? 0 : ms, errc);
    run_q(nh, tag);
    if (kind == K_BADOP || kind == K_BADFN) do_reset({tag, "_rst"});
  endtask

  task automatic test_reset();
    set_instr(6'b000000, 6'b100000, 1'b0);
    do_reset("reset");
  endtask

  task automatic test_rtype_add();
    set_instr(6'b000000, 6'b100000, 1'b0);
    build(K_R, 6'b100000, 1'b0, 0, 0, 0);
    run_q(1'b0, "add");
  endtask

  task automatic test_lw_stall();
    run_instr(K_LW, 1'b0, 0, 2, 0, 1'b0, "lw_stall");
  endtask

  task automatic test_branches();
    run_instr(K_BEQ, 1'b1, 0, 0, 0, 1'b0, "beq_z1");
    run_instr(K_BNE, 1'b1, 0, 0, 0, 1'b0, "bne_z1");
    run_instr(K_BNE, 1'b0, 0, 0, 0, 1'b0, "bne_z0");
  endtask

  // Store stalled three cycles, then reset lands while the write is pending.
  task automatic test_sw_reset();
    set_instr(6'b101011, 6'b000000, 1'b0);
    build(K_SW, 6'b000000, 1'b0, 0, 3, 0);
    void'(q.pop_back());
    run_q(1'b0, "sw_stall");
    reset = 1'b1;
    bus_hs.memready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_hs.memwrite !== 1'b0 || bus_hs.regwrite !== 1'b0 || bus_hs.state !== 4'd5) begin
      errors++;
      $display("FAIL sw_reset cycle: got memwrite=%b regwrite=%b state=%0d expected 0 0 5",
               bus_hs.memwrite, bus_hs.regwrite, bus_hs.state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus_hs.state !== 4'd0) begin
      errors++;
      $display("FAIL sw_reset state after edge: got %0d expected 0", bus_hs.state);
    end
  endtask

  task automatic test_err();
    set_instr(6'b111111, 6'b100000, 1'b0);
    build(K_BADOP, 6'b100000, 1'b0, 0, 0, 10);
    run_q(1'b0, "err_op");
    do_reset("err_op_rst");
    set_instr(6'b000000, 6'b000111, 1'b0);
    build(K_BADFN, 6'b000111, 1'b0, 0, 0, 10);
    run_q(1'b0, "err_fn");
    do_reset("err_fn_rst");
  endtask

  task automatic test_no_handshake();
    do_reset("nh_start");
    run_instr(K_J, 1'b0, 0, 0, 0, 1'b1, "nh_j");
    for (int i = 0; i < 12; i++)
      run_instr($urandom_range(0, 8), rb(), 0, 0, $urandom_range(1, 3), 1'b1, "nh_rand");
  endtask

  task automatic test_random();
    do_reset("rand_start");
    for (int i = 0; i < 60; i++)
      run_instr($urandom_range(0, 8), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(1, 4), 1'b0, "rand");
  endtask

  task automatic test_back_to_back();
    do_reset("b2b_start");
    for (int k = 0; k <= K_J; k++)
      run_instr(k, 1'b0, 0, 0, 0, 1'b0, "b2b");
  endtask

  initial begin
    reset = 1'b1;
    bus_hs.memready = 1'b1;
    bus_nh.memready = 1'b0;
    test_reset();
    test_rtype_add();
    test_lw_stall();
    test_branches();
    test_sw_reset();
    test_err();
    test_no_handshake();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the 32-bit multi-cycle MIPS core. It drives every control input of the datapath stage and consumes the datapath's op, funct and zero outputs.
- Implements the main instruction-sequencing FSM and the ALU decoder.
- Adds a memory-ready handshake so that fetch, load and store can stall on slow memory.
- Adds a sticky error state for undefined opcodes and undefined R-type funct codes.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for memready; when 0 memready is ignored and treated as constant 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instr[31:26] from datapath.
- funct  in  6  instr[5:0] from datapath.
- zero  in  1  ALU zero flag from datapath.
- memready  in  1  memory completed the current access this cycle.
- pcen  out  1  PC register enable.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write enable.
- memwrite  out  1  memory write strobe.
- alusrca  out  1  0 = pc, 1 = A register.
- iord  out  1  0 = pc, 1 = aluout as memory address.
- memtoreg  out  1  0 = aluout, 1 = data register.
- regdst  out  1  0 = rt, 1 = rd.
- alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- pcsrc  out  2  00 = aluresult, 01 = aluout, 10 = jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  out  4  current FSM state, for debug.
- err  out  1  high while in ERR.

Behaviour:
- State register: 4 bits, updated on posedge clk. reset=1 at the edge loads FETCH.
- Outputs are combinational from state plus op, funct, zero and memready.
- While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0.
- Any output not listed for a state is 0; alucontrol defaults to 010.
- Let rdy = memready when MEM_HANDSHAKE=1, else 1.

State encodings and actions:
- FETCH (0): iord=0, alusrca=0, alusrcb=01, pcsrc=00, add. irwrite=rdy, pcen=rdy. Go to DECODE if rdy, else hold.
- DECODE (1): alusrca=0, alusrcb=11, add (branch target written to aluout). Next state by op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 with a legal funct -> RTYPEEX
  - 000100 -> BEQEX
  - 000101 -> BNEEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - anything else, or 000000 with an illegal funct -> ERR
- MEMADR (2): alusrca=1, alusrcb=10, add. Go to MEMRD if op=lw, MEMWR if op=sw.
- MEMRD (3): iord=1. Go to MEMWB when rdy, else hold.
- MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
- MEMWR (5): iord=1, memwrite=1, held every cycle until rdy. Go to FETCH on rdy.
- RTYPEEX (6): alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Go to RTYPEWB.
- RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
- BEQEX (8): alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Go to FETCH.
- BNEEX (12): as BEQEX, but pcen=~zero.
- ADDIEX (9): alusrca=1, alusrcb=10, add. Go to ADDIWB.
- ADDIWB (10): regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
- JEX (11): pcsrc=10, pcen=1. Go to FETCH.
- ERR (13): all enables 0, err=1. Held until reset.
- Encodings 14 and 15 are unreachable; if entered, next state is FETCH.

Rules and boundary cases:
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each cycle memready is low in FETCH, MEMRD or MEMWR adds one cycle.
- memready in any other state is ignored.
- irwrite and pcen pulse exactly once per instruction fetch.
- regwrite is high for exactly one cycle per lw, R-type or addi, and never otherwise.
- Reset asserted mid-instruction (any state, including a stalled MEMWR): state becomes FETCH on that edge, and memwrite drops in the same cycle.

Test Plan:
- Reset, then run add $3,$1,$2 (op 000000, funct 100000) with memready=1 -> states 0,1,6,7,0; alucontrol=010 in RTYPEEX; regwrite=1 and regdst=1 only in cycle 4.
- lw with memready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 for 3 cycles; memtoreg=1 and regwrite=1 in MEMWB only.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX. bne with zero=1 -> pcen=0. bne with zero=0 -> pcen=1.
- sw with memready=0 for 3 cycles, then reset asserted -> memwrite=1 for those 3 cycles, memwrite=0 in the reset cycle, state=0 after the edge, no regwrite at any point.
- op=111111 in DECODE -> ERR; err=1 and all enables 0 for 10 cycles; reset returns state to 0. Repeat with R-type funct 000111 -> ERR.
- MEM_HANDSHAKE=0 with memready tied 0 -> j completes in 3 cycles; pcsrc=10 and pcen=1 in JEX.
